// File: rtl/aes_host_sequencer.sv
// aes_host_sequencer
//   Host-side driver for an aes_cipher_top style core. Collects a 128-bit key
//   and a 128-bit plaintext as eight 32-bit valid/ready words, pulses aes_ld
//   for one cycle, waits for aes_done, captures aes_text_out and replays the
//   ciphertext as four 32-bit valid/ready words. If aes_done never arrives
//   within TIMEOUT_CYCLES cycles, it raises a sticky timeout_err and returns
//   to LOAD. The next accepted input word clears timeout_err.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  input word handshake, in_data = key MSW first, then plaintext
//   out_valid/out_ready output word handshake, out_data = ciphertext MSW first
//   aes_ld             one-cycle load strobe to the core
//   aes_key            key to the core
//   aes_text_in        plaintext to the core
//   aes_done           completion strobe from the core
//   aes_text_out       ciphertext from the core
//   busy               high outside LOAD
//   timeout_err        sticky timeout flag
module aes_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [2:0]     word_cnt;
  logic [7:0]     wait_cnt;
  logic [1:0]     out_cnt;
  logic [127:0]   out_shift;
  logic           in_fire;
  logic           out_fire;

  assign in_ready = (state == LOAD) && !rst;
  assign busy     = (state != LOAD);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:  if (in_fire && (word_cnt == 3'd7)) state_nx = KICK;
      // A done strobe seen in KICK is a leftover from an earlier operation.
      KICK:  state_nx = WAIT;
      // Done takes priority over a timeout landing in the same cycle.
      WAIT:  if (aes_done) state_nx = DRAIN;
             else if (wait_cnt == WAIT_LAST) state_nx = LOAD;
      DRAIN: if (out_fire && (out_cnt == 2'd3)) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= '0;
      wait_cnt    <= '0;
      out_cnt     <= '0;
      out_shift   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      aes_ld      <= 1'b0;
      aes_key     <= '0;
      aes_text_in <= '0;
      timeout_err <= 1'b0;
    end else begin
      aes_ld <= (state_nx == KICK);

      if (in_fire) begin
        word_cnt    <= word_cnt + 3'd1;
        timeout_err <= 1'b0;
        unique case (word_cnt)
          3'd0: aes_key[127:96]     <= in_data;
          3'd1: aes_key[95:64]      <= in_data;
          3'd2: aes_key[63:32]      <= in_data;
          3'd3: aes_key[31:0]       <= in_data;
          3'd4: aes_text_in[127:96] <= in_data;
          3'd5: aes_text_in[95:64]  <= in_data;
          3'd6: aes_text_in[63:32]  <= in_data;
          3'd7: aes_text_in[31:0]   <= in_data;
          default: ;
        endcase
      end

      if (state == KICK) wait_cnt <= '0;

      if (state == WAIT) begin
        if (aes_done) begin
          out_shift <= aes_text_out;
          out_data  <= aes_text_out[127:96];
          out_valid <= 1'b1;
          out_cnt   <= '0;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end

      // out_data is preloaded from the word after the one being accepted,
      // so it is already valid the cycle after each handshake.
      if ((state == DRAIN) && out_fire) begin
        out_cnt   <= out_cnt + 2'd1;
        out_shift <= {out_shift[95:0], 32'h0};
        out_data  <= out_shift[95:64];
        if (out_cnt == 2'd3) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_host_sequencer.sv
module tb_aes_host_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_done = 1'b0;
  logic [127:0] aes_text_out = '0;
  logic         busy;
  logic         timeout_err;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned ld_count = 0;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_host_sequencer #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_done(aes_done), .aes_text_out(aes_text_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (aes_ld === 1'b1) ld_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vec_word(input int unsigned i);
    logic [255:0] v;
    v = {KEY, PT};
    return v[255 - 32*i -: 32];
  endfunction

  task automatic send_word(input logic [31:0] d, input int unsigned gap, output bit ok);
    bit r;
    in_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int unsigned c = 0; c < 20 && !ok; c++) begin
      r = in_ready;
      tick();
      ok = r;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int unsigned maxgap, output bit ok);
    bit w_ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      send_word(vec_word(i), (maxgap != 0) ? $urandom_range(maxgap, 0) : 0, w_ok);
      ok = ok && w_ok;
    end
  endtask

  task automatic core_done(input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) tick();
    aes_done     = 1'b1;
    aes_text_out = CT;
    tick();
    aes_done     = 1'b0;
    aes_text_out = '0;
  endtask

  // ready_period: out_ready high one cycle in every ready_period (0 = always)
  task automatic drain(input int unsigned ready_period, output logic [127:0] got,
                       output bit stable, output bit rdy_low, output bit ok);
    int unsigned k = 0;
    int unsigned cyc = 0;
    bit held_flag = 1'b0;
    logic [31:0] held = '0;
    got = '0; stable = 1'b1; rdy_low = 1'b1;
    while (k < 4 && cyc < 40) begin
      out_ready = (ready_period == 0) || ((cyc % ready_period) == 0);
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      if (held_flag && (out_valid !== 1'b1 || out_data !== held)) stable = 1'b0;
      held_flag = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        got = {got[95:0], out_data};
        k++;
      end else if (out_valid === 1'b1) begin
        held_flag = 1'b1;
        held = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    ok = (k == 4);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({aes_ld, aes_key, aes_text_in, out_valid, out_data, timeout_err, busy, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ld=%b key=%h txt=%h ov=%b od=%h to=%b busy=%b rdy=%b want all 0",
               aes_ld, aes_key, aes_text_in, out_valid, out_data, timeout_err, busy, in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_fips();
    bit ok, st, rl;
    logic [127:0] got;
    int unsigned ld0 = ld_count;
    send_block(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fips_send got accepted=%b want 1", ok); end
    checks++;
    if (aes_ld !== 1'b1) begin failures++; $display("FAIL fips_ld_latency got %b want 1", aes_ld); end
    checks++;
    if (aes_key !== KEY || aes_text_in !== PT) begin
      failures++; $display("FAIL fips_key_text got %h/%h want %h/%h", aes_key, aes_text_in, KEY, PT);
    end
    core_done(11);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h69c4e0d8) begin
      failures++; $display("FAIL fips_first_word got v=%b %h want v=1 69c4e0d8", out_valid, out_data);
    end
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL fips_cipher got %h want %h", got, CT); end
    checks++;
    if (ld_count - ld0 != 1) begin failures++; $display("FAIL fips_ld_pulses got %0d want 1", ld_count - ld0); end
    checks++;
    if (timeout_err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL fips_idle got to=%b ov=%b busy=%b rdy=%b want 0 0 0 1",
                           timeout_err, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok, st, rl;
    logic [127:0] got;
    send_block(0, ok);
    core_done(2);
    drain(3, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL bp_cipher got %h want %h", got, CT); end
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL bp_stable got %b want 1", st); end
    checks++;
    if (rl !== 1'b1) begin failures++; $display("FAIL bp_in_ready_low got %b want 1", rl); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_timeout();
    bit ok, st, rl;
    logic [127:0] got;
    int unsigned ld0 = ld_count;
    send_block(0, ok);
    for (int unsigned i = 0; i < 32; i++) tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL to_early got to=%b busy=%b want 0 1", timeout_err, busy);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL to_flag got to=%b busy=%b rdy=%b want 1 0 1", timeout_err, busy, in_ready);
    end
    checks++;
    if (aes_key !== KEY || aes_text_in !== PT || out_valid !== 1'b0) begin
      failures++; $display("FAIL to_retain got %h/%h ov=%b want %h/%h ov=0", aes_key, aes_text_in, out_valid, KEY, PT);
    end
    checks++;
    if (ld_count - ld0 != 1) begin failures++; $display("FAIL to_ld_pulses got %0d want 1", ld_count - ld0); end
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    send_word(vec_word(0), 0, ok);
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got %b want 0", timeout_err); end
    for (int unsigned i = 1; i < 8; i++) send_word(vec_word(i), 0, ok);
    checks++;
    if (aes_ld !== 1'b1) begin failures++; $display("FAIL to_reload_ld got %b want 1", aes_ld); end
    core_done(3);
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL to_cipher got %h want %h", got, CT); end
  endtask

  task automatic test_done_at_timeout();
    bit ok, st, rl;
    logic [127:0] got;
    send_block(0, ok);
    core_done(32);
    checks++;
    if (out_valid !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL edge_done got ov=%b to=%b busy=%b want 1 0 1", out_valid, timeout_err, busy);
    end
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL edge_cipher got %h want %h", got, CT); end
  endtask

  task automatic test_stale_done();
    bit ok, st, rl;
    logic [127:0] got;
    send_block(0, ok);
    aes_done     = 1'b1;
    aes_text_out = ~CT;
    tick();
    aes_done     = 1'b0;
    aes_text_out = '0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL stale_ignored got ov=%b busy=%b want 0 1", out_valid, busy);
    end
    core_done(10);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL stale_capture got %b want 1", out_valid); end
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL stale_cipher got %h want %h", got, CT); end
  endtask

  task automatic test_reset_mid_op();
    bit ok, st, rl;
    logic [127:0] got;
    send_block(0, ok);
    for (int unsigned i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({aes_ld, aes_key, aes_text_in, out_valid, out_data, timeout_err, busy, in_ready} !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs got ld=%b key=%h txt=%h ov=%b od=%h to=%b busy=%b rdy=%b want all 0",
               aes_ld, aes_key, aes_text_in, out_valid, out_data, timeout_err, busy, in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_in_ready got %b want 1", in_ready); end
    send_block(0, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (aes_ld !== 1'b0) begin failures++; $display("FAIL rst_kick_ld got %b want 0", aes_ld); end
    tick();
    rst = 1'b0;
    #1;
    send_block(0, ok);
    core_done(6);
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL rst_cipher got %h want %h", got, CT); end
  endtask

  task automatic test_input_gaps();
    bit ok, st, rl;
    logic [127:0] got;
    send_block(3, ok);
    checks++;
    if (!ok || aes_ld !== 1'b1) begin failures++; $display("FAIL gap_ld got ok=%b ld=%b want 1 1", ok, aes_ld); end
    checks++;
    if (aes_key !== KEY || aes_text_in !== PT) begin
      failures++; $display("FAIL gap_key_text got %h/%h want %h/%h", aes_key, aes_text_in, KEY, PT);
    end
    core_done(4);
    drain(0, got, st, rl, ok);
    checks++;
    if (!ok || got !== CT) begin failures++; $display("FAIL gap_cipher got %h want %h", got, CT); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_timeout();
    test_done_at_timeout();
    test_stale_done();
    test_reset_mid_op();
    test_input_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
